// File: rtl/alu_pkg.sv
// Shared definitions for the Hack-style ALU: default width, control word layout and op codes.
// Optional carry/overflow outputs are enabled with the ALU_CARRY_EN macro.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_ZERO  = 6'b101010;
    localparam alu_ctrl_t ALU_ONE   = 6'b111111;
    localparam alu_ctrl_t ALU_NEG1  = 6'b111010;
    localparam alu_ctrl_t ALU_X     = 6'b001100;
    localparam alu_ctrl_t ALU_Y     = 6'b110000;
    localparam alu_ctrl_t ALU_NOTX  = 6'b001101;
    localparam alu_ctrl_t ALU_NOTY  = 6'b110001;
    localparam alu_ctrl_t ALU_NEGX  = 6'b001111;
    localparam alu_ctrl_t ALU_NEGY  = 6'b110011;
    localparam alu_ctrl_t ALU_XP1   = 6'b011111;
    localparam alu_ctrl_t ALU_YP1   = 6'b110111;
    localparam alu_ctrl_t ALU_XM1   = 6'b001110;
    localparam alu_ctrl_t ALU_YM1   = 6'b110010;
    localparam alu_ctrl_t ALU_XPY   = 6'b000010;
    localparam alu_ctrl_t ALU_XMY   = 6'b010011;
    localparam alu_ctrl_t ALU_YMX   = 6'b000111;
    localparam alu_ctrl_t ALU_XANDY = 6'b000000;
    localparam alu_ctrl_t ALU_XORY  = 6'b010101;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational Hack ALU core: operand conditioning, add/and, result negation and flags.
// Carry and signed-overflow outputs exist only when ALU_CARRY_EN is defined.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] res,
    output logic             zr,
    output logic             ng
`ifdef ALU_CARRY_EN
    ,
    output logic             carry,
    output logic             ov
`endif
);

    logic [WIDTH-1:0] xa, xb, ya, yb, sum, r;

    assign xa = ctrl.zx ? '0 : x;
    assign xb = ctrl.nx ? ~xa : xa;
    assign ya = ctrl.zy ? '0 : y;
    assign yb = ctrl.ny ? ~ya : ya;

`ifdef ALU_CARRY_EN
    // One extra adder bit exposes the carry-out; overflow compares operand and sum signs.
    logic [WIDTH:0] sumWide;
    assign sumWide = {1'b0, xb} + {1'b0, yb};
    assign sum     = sumWide[WIDTH-1:0];
    assign carry   = ctrl.f & sumWide[WIDTH];
    assign ov      = ctrl.f & (xb[WIDTH-1] == yb[WIDTH-1]) & (sum[WIDTH-1] != xb[WIDTH-1]);
`else
    assign sum = xb + yb;
`endif

    assign r   = ctrl.f ? sum : (xb & yb);
    assign res = ctrl.no ? ~r : r;
    assign zr  = (res == '0);
    assign ng  = res[WIDTH-1];

endmodule

// File: rtl/alu.sv
// Registered Hack ALU: one-cycle latency, results captured only when in_valid is high.
// Define ALU_CARRY_EN to add registered carry and ov outputs.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid
`ifdef ALU_CARRY_EN
    ,
    output logic             carry,
    output logic             ov
`endif
);

    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] resComb;
    logic             zrComb, ngComb;

    assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

`ifdef ALU_CARRY_EN
    logic carryComb, ovComb;

    alu_comb #(.WIDTH(WIDTH)) core (
        .x     (x),
        .y     (y),
        .ctrl  (ctrl),
        .res   (resComb),
        .zr    (zrComb),
        .ng    (ngComb),
        .carry (carryComb),
        .ov    (ovComb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
            ov    <= 1'b0;
        end else if (in_valid) begin
            carry <= carryComb;
            ov    <= ovComb;
        end
    end
`else
    alu_comb #(.WIDTH(WIDTH)) core (
        .x    (x),
        .y    (y),
        .ctrl (ctrl),
        .res  (resComb),
        .zr   (zrComb),
        .ng   (ngComb)
    );
`endif

    // Reset value reflects a zero result, so zr starts high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            zr        <= 1'b1;
            ng        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= resComb;
                zr  <= zrComb;
                ng  <= ngComb;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, random vectors against a reference model, resets.
// Define ALU_CARRY_EN to also exercise the carry and ov outputs.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
    logic [W-1:0] out;
    logic         zr, ng, out_valid;
`ifdef ALU_CARRY_EN
    logic         carry, ov;
`endif

    int checkCount = 0;
    int errorCount = 0;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .out_valid (out_valid)
`ifdef ALU_CARRY_EN
        ,
        .carry     (carry),
        .ov        (ov)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expectResult(input string tag, input logic [W-1:0] eOut, input logic eZr,
                                input logic eNg, input logic eValid);
        checkOutput({tag, ".out"}, out, eOut);
        checkOutput({tag, ".zr"}, W'(zr), W'(eZr));
        checkOutput({tag, ".ng"}, W'(ng), W'(eNg));
        checkOutput({tag, ".valid"}, W'(out_valid), W'(eValid));
    endtask

    // Drive on the falling edge, then sample 1 time unit after the capturing rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] xi, input logic [W-1:0] yi,
                                 input alu_ctrl_t c);
        @(negedge clk);
        in_valid = v;
        x = xi;
        y = yi;
        {zx, nx, zy, ny, f, no} = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] modelSum(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return s[W:0];
    endfunction

    function automatic logic [W-1:0] modelRes(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                              input alu_ctrl_t c);
        logic [W-1:0] a, b, r;
        a = c.zx ? 16'h0000 : xi;
        if (c.nx) a = a ^ 16'hFFFF;
        b = c.zy ? 16'h0000 : yi;
        if (c.ny) b = b ^ 16'hFFFF;
        if (c.f) begin
            logic [W:0] s;
            s = modelSum(a, b);
            r = s[W-1:0];
        end else begin
            r = a & b;
        end
        return c.no ? (r ^ 16'hFFFF) : r;
    endfunction

    initial begin
        logic [W-1:0] expOut;
        logic [W-1:0] rx, ry;
        alu_ctrl_t    rc;
        logic         rv;

        // Reset held low while inputs churn.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, W'($urandom), W'($urandom), alu_ctrl_t'(6'($urandom)));
            expectResult($sformatf("reset%0d", i), 16'h0000, 1'b1, 1'b0, 1'b0);
        end
`ifdef ALU_CARRY_EN
        checkOutput("reset.carry", W'(carry), 16'h0000);
        checkOutput("reset.ov", W'(ov), 16'h0000);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        applyStimulus(1'b1, 16'd5, 16'd3, ALU_XPY);
        expectResult("add", 16'h0008, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd3, 16'd5, ALU_XMY);
        expectResult("sub", 16'hFFFE, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'hABCD, ALU_ZERO);
        expectResult("zero", 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'hABCD, ALU_NEG1);
        expectResult("neg1", 16'hFFFF, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'hABCD, ALU_ONE);
        expectResult("one", 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1234, 16'hABCD, ALU_YMX);
        expectResult("ymx", 16'h9999, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h0F0F, 16'h00FF, ALU_XANDY);
        expectResult("and", 16'h000F, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0F0F, 16'h00FF, ALU_XORY);
        expectResult("or", 16'h0FFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h1111, 16'h2222, ALU_ZERO);
        expectResult("hold", 16'h0FFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'hFFFF, 16'h8000, ALU_NEG1);
        expectResult("hold2", 16'h0FFF, 1'b0, 1'b0, 1'b0);

        // Random vectors against the reference model; idle cycles must hold the last result.
        expOut = 16'h0FFF;
        for (int i = 0; i < 16; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = alu_ctrl_t'(6'($urandom));
            rv = ($urandom_range(0, 3) != 0);
            applyStimulus(rv, rx, ry, rc);
            if (rv) expOut = modelRes(rx, ry, rc);
            expectResult($sformatf("rand%0d", i), expOut, expOut == 16'h0000, expOut[W-1], rv);
        end

        // Asynchronous reset between edges clears outputs without waiting for a clock.
        applyStimulus(1'b1, 16'h8001, 16'h0000, ALU_X);
        expectResult("preReset", 16'h8001, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expectResult("midReset", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0000, 16'h0042, ALU_Y);
        expectResult("postReset", 16'h0042, 1'b0, 1'b0, 1'b1);

`ifdef ALU_CARRY_EN
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, ALU_XPY);
        expectResult("ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
        checkOutput("ovf.ov", W'(ov), 16'h0001);
        checkOutput("ovf.carry", W'(carry), 16'h0000);
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, ALU_XPY);
        expectResult("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        checkOutput("wrap.ov", W'(ov), 16'h0000);
        checkOutput("wrap.carry", W'(carry), 16'h0001);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, ALU_XANDY);
        checkOutput("and.carry", W'(carry), 16'h0000);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, ALU_XPY);
        checkOutput("holdCarry", W'(carry), 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
